// File: rtl/machina_pkg.sv
// Shared types and arithmetic for the backward-pass block.
//   state_e   : pass sequencer states (load, weight read address, weight read data, output)
//   mul_shift : signed a*b followed by an arithmetic right shift; callers keep the low W bits
package machina_pkg;

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StOut  = 2'd3
    } state_e;

    // Widest operand supported by mul_shift; W must not exceed this.
    localparam int unsigned MaxW = 32;

    function automatic logic signed [2*MaxW-1:0] mul_shift(
        input logic signed [MaxW-1:0] a,
        input logic signed [MaxW-1:0] b,
        input int unsigned            s
    );
        logic signed [2*MaxW-1:0] p;
        p = (2*MaxW)'(a) * (2*MaxW)'(b);
        return p >>> s;
    endfunction

endpackage

// File: rtl/backward_scale.sv
// scale: fixed-point multiply with arithmetic right shift, truncated to W bits.
//   a, b : W-bit two's complement operands
//   y    : low W bits of (a*b) >>> S
module scale
    import machina_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned S = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic signed [2*MaxW-1:0] full;
    logic                     unused_hi;

    assign full      = mul_shift(MaxW'($signed(a)), MaxW'($signed(b)), S);
    assign y         = full[W-1:0];
    // Upper product bits are dropped on purpose: results wrap, no saturation.
    assign unused_hi = ^full[2*MaxW-1:W];

endmodule

// File: rtl/backward.sv
// backward: one backward-propagation step for a single neuron with N weights.
// Collects inputs x[0..N-1] and one error delta, then for each n reads w[n] from memory,
// emits the propagated error e[n] = (delta*w[n]) >>> Q and, when BACKWARD_UPDATE_EN is
// defined, writes back w[n] - ((delta*x[n]) >>> (Q+R)).
// Ports (all stb/rdy handshakes transfer on a rising clk edge with both high):
//   clk, rst                   : clock, asynchronous active-low reset
//   s_x_stb/dat/adr, s_x_rdy   : forward input x[adr] to store
//   s_e_stb/dat, s_e_rdy       : incoming error delta
//   ar_stb/dat, ar_rdy         : weight read address
//   r_stb/dat, r_rdy           : weight read data
//   aw_stb/dat, aw_rdy         : weight write address (BACKWARD_UPDATE_EN only)
//   w_stb/dat, w_rdy           : weight write data (BACKWARD_UPDATE_EN only)
//   m_e_stb/dat/adr, m_e_rdy   : propagated error e[adr]
module backward
    import machina_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4,
    parameter int unsigned Q = 8,
    parameter int unsigned R = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_x_stb,
    input  logic [W-1:0]         s_x_dat,
    input  logic [$clog2(N)-1:0] s_x_adr,
    output logic                 s_x_rdy,
    input  logic                 s_e_stb,
    input  logic [W-1:0]         s_e_dat,
    output logic                 s_e_rdy,
    output logic                 ar_stb,
    output logic [$clog2(N)-1:0] ar_dat,
    input  logic                 ar_rdy,
    input  logic                 r_stb,
    input  logic [W-1:0]         r_dat,
    output logic                 r_rdy,
    output logic                 aw_stb,
    output logic [$clog2(N)-1:0] aw_dat,
    input  logic                 aw_rdy,
    output logic                 w_stb,
    output logic [W-1:0]         w_dat,
    input  logic                 w_rdy,
    output logic                 m_e_stb,
    output logic [W-1:0]         m_e_dat,
    output logic [$clog2(N)-1:0] m_e_adr,
    input  logic                 m_e_rdy
);

    localparam int unsigned AW = $clog2(N);

    state_e         state_q, state_d;
    logic [AW-1:0]  n_q;
    logic [W-1:0]   x_q [N];
    logic [N-1:0]   valid_q;
    logic [W-1:0]   delta_q;
    logic           delta_valid_q;
    logic [W-1:0]   w_q;
    logic           m_done_q;
    // Held low through reset so no input is accepted until the first edge after release.
    logic           rdy_en_q;

    logic           x_fire, e_fire, ar_fire, r_fire, m_fire;
    logic           m_ok, aw_ok, w_ok, out_done, last;
    logic [W-1:0]   upd_term;

    assign s_x_rdy = rdy_en_q & (state_q == StLoad);
    assign s_e_rdy = rdy_en_q & (state_q == StLoad) & ~delta_valid_q;
    assign ar_stb  = (state_q == StAddr);
    assign ar_dat  = n_q;
    assign r_rdy   = (state_q == StData);
    assign m_e_stb = (state_q == StOut) & ~m_done_q;
    assign m_e_adr = n_q;

    assign x_fire  = s_x_stb & s_x_rdy;
    assign e_fire  = s_e_stb & s_e_rdy;
    assign ar_fire = ar_stb & ar_rdy;
    assign r_fire  = r_stb & r_rdy;
    assign m_fire  = m_e_stb & m_e_rdy;

    assign m_ok     = m_done_q | m_fire;
    assign out_done = (state_q == StOut) & m_ok & aw_ok & w_ok;
    assign last     = (n_q == AW'(N - 1));

    scale #(
        .W (W),
        .S (Q)
    ) u_scale_err (
        .a (delta_q),
        .b (w_q),
        .y (m_e_dat)
    );

    scale #(
        .W (W),
        .S (Q + R)
    ) u_scale_upd (
        .a (delta_q),
        .b (x_q[n_q]),
        .y (upd_term)
    );

`ifdef BACKWARD_UPDATE_EN
    logic aw_done_q, w_done_q;

    assign aw_stb = (state_q == StOut) & ~aw_done_q;
    assign aw_dat = n_q;
    assign w_stb  = (state_q == StOut) & ~w_done_q;
    assign w_dat  = w_q - upd_term;
    assign aw_ok  = aw_done_q | (aw_stb & aw_rdy);
    assign w_ok   = w_done_q | (w_stb & w_rdy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (out_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_stb && aw_rdy) aw_done_q <= 1'b1;
            if (w_stb && w_rdy)   w_done_q  <= 1'b1;
        end
    end
`else
    logic unused_upd;

    assign aw_stb     = 1'b0;
    assign aw_dat     = '0;
    assign w_stb      = 1'b0;
    assign w_dat      = '0;
    assign aw_ok      = 1'b1;
    assign w_ok       = 1'b1;
    assign unused_upd = ^{aw_rdy, w_rdy, upd_term};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: if (&valid_q && delta_valid_q) state_d = StAddr;
            StAddr: if (ar_fire)                   state_d = StData;
            StData: if (r_fire)                    state_d = StOut;
            StOut:  if (out_done)                  state_d = last ? StLoad : StAddr;
            default:                               state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StLoad;
            n_q           <= '0;
            valid_q       <= '0;
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
            w_q           <= '0;
            m_done_q      <= 1'b0;
            rdy_en_q      <= 1'b0;
            for (int i = 0; i < int'(N); i++) x_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (x_fire) begin
                x_q[s_x_adr]     <= s_x_dat;
                valid_q[s_x_adr] <= 1'b1;
            end
            if (e_fire) begin
                delta_q       <= s_e_dat;
                delta_valid_q <= 1'b1;
            end
            if (r_fire) w_q <= r_dat;
            if (out_done) begin
                m_done_q <= 1'b0;
                if (last) begin
                    n_q           <= '0;
                    valid_q       <= '0;
                    delta_valid_q <= 1'b0;
                end else begin
                    n_q <= n_q + 1'b1;
                end
            end else if (m_fire) begin
                m_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_backward.sv
// Self-checking bench for backward (W=16, N=4, Q=8, R=0) with a weight memory model and
// a scoreboard of expected propagated errors. Build with or without BACKWARD_UPDATE_EN.
module tb_backward;

    localparam int W = 16;
    localparam int N = 4;
`ifdef BACKWARD_UPDATE_EN
    localparam bit Upd = 1'b1;
`else
    localparam bit Upd = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_x_stb, s_x_rdy, s_e_stb, s_e_rdy;
    logic [W-1:0]  s_x_dat, s_e_dat;
    logic [1:0]    s_x_adr;
    logic          ar_stb, ar_rdy, r_stb, r_rdy;
    logic [1:0]    ar_dat;
    logic [W-1:0]  r_dat;
    logic          aw_stb, aw_rdy, w_stb, w_rdy;
    logic [1:0]    aw_dat;
    logic [W-1:0]  w_dat;
    logic          m_e_stb, m_e_rdy;
    logic [W-1:0]  m_e_dat;
    logic [1:0]    m_e_adr;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [31:0]   sb_q [$];
    logic [W-1:0]  mem [N];
    logic [W-1:0]  exp_mem [N];
    logic          preset_en = 1'b0;
    logic [W-1:0]  preset_val = '0;
    int            hold_adr = -1;
    logic          stall_mode = 1'b0;
    int            stall_cnt = 0;
    int            busy = 0;
    int            aw_seen = 0;
    logic          held_valid = 1'b0;
    logic [W-1:0]  held_dat;
    logic [1:0]    held_adr;

    always #5 clk = ~clk;

    backward #(
        .W (W),
        .N (N),
        .Q (8),
        .R (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_x_stb (s_x_stb),
        .s_x_dat (s_x_dat),
        .s_x_adr (s_x_adr),
        .s_x_rdy (s_x_rdy),
        .s_e_stb (s_e_stb),
        .s_e_dat (s_e_dat),
        .s_e_rdy (s_e_rdy),
        .ar_stb  (ar_stb),
        .ar_dat  (ar_dat),
        .ar_rdy  (ar_rdy),
        .r_stb   (r_stb),
        .r_dat   (r_dat),
        .r_rdy   (r_rdy),
        .aw_stb  (aw_stb),
        .aw_dat  (aw_dat),
        .aw_rdy  (aw_rdy),
        .w_stb   (w_stb),
        .w_dat   (w_dat),
        .w_rdy   (w_rdy),
        .m_e_stb (m_e_stb),
        .m_e_dat (m_e_dat),
        .m_e_adr (m_e_adr),
        .m_e_rdy (m_e_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed product, arithmetic shift, keep 16 LSBs.
    function automatic logic [W-1:0] mdl(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int s);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> s;
        return p[W-1:0];
    endfunction

    // Weight memory: read data one cycle after the address, writes when aw and w both fire.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stb <= 1'b0;
            r_dat <= '0;
        end else begin
            if (r_stb && r_rdy) r_stb <= 1'b0;
            if (ar_stb && ar_rdy && (int'(ar_dat) != hold_adr)) begin
                r_stb <= 1'b1;
                r_dat <= mem[ar_dat];
            end
            if (aw_stb && aw_rdy && w_stb && w_rdy) mem[aw_dat] <= w_dat;
            if (preset_en) for (int i = 0; i < N; i++) mem[i] <= preset_val;
        end
    end

    // m_e_rdy: always ready, or held low 5 cycles per element in stall mode.
    always @(posedge clk) begin
        if (!stall_mode) begin
            m_e_rdy <= 1'b1;
        end else if (!m_e_stb || m_e_rdy) begin
            m_e_rdy   <= 1'b0;
            stall_cnt <= 0;
        end else begin
            if (stall_cnt == 4) m_e_rdy <= 1'b1;
            stall_cnt <= stall_cnt + 1;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            if (ar_stb || r_rdy || m_e_stb) busy++;
            if (aw_stb || w_stb) aw_seen++;
            if (held_valid) begin
                check("me_hold_stb", 32'(m_e_stb), 32'd1);
                check("me_hold_dat", 32'(m_e_dat), 32'(held_dat));
                check("me_hold_adr", 32'(m_e_adr), 32'(held_adr));
                check("me_hold_no_ar", 32'(ar_stb), 32'd0);
            end
            held_valid = m_e_stb && !m_e_rdy && stall_mode;
            held_dat   = m_e_dat;
            held_adr   = m_e_adr;
            if (m_e_stb && m_e_rdy) begin
                if (sb_q.size() == 0) begin
                    check("me_unexpected", 32'(m_e_adr), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("me_adr", 32'(m_e_adr), 32'(e[17:16]));
                    check("me_dat", 32'(m_e_dat), 32'(e[15:0]));
                end
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic preset(input logic [W-1:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        @(posedge clk); #1;
        preset_en  = 1'b0;
    endtask

    // Push expected e[0..cnt-1] and set expected memory after the pass.
    task automatic expect_pass(input logic [W-1:0] d, input logic [W-1:0] wv,
                               input logic [W-1:0] xv, input int cnt);
        logic [W-1:0] m;
        m = mdl(d, wv, 8);
        for (int i = 0; i < N; i++) begin
            if (i < cnt) begin
                sb_q.push_back({14'd0, 2'(i), m});
                exp_mem[i] = Upd ? wv - mdl(d, xv, 8) : wv;
            end else begin
                exp_mem[i] = wv;
            end
        end
    endtask

    // Drive x and/or delta; each strobe drops on its own transfer. Call at posedge+1.
    task automatic send(input bit do_x, input int adr, input logic [W-1:0] xd,
                        input bit do_e, input logic [W-1:0] ed);
        bit xp, ep, xf, ef;
        int t;
        xp = do_x; ep = do_e; t = 0;
        s_x_stb = xp; s_x_adr = 2'(adr); s_x_dat = xd;
        s_e_stb = ep; s_e_dat = ed;
        while ((xp || ep) && t < 50) begin
            @(negedge clk);
            xf = xp && s_x_rdy;
            ef = ep && s_e_rdy;
            @(posedge clk); #1;
            if (xf) begin xp = 1'b0; s_x_stb = 1'b0; end
            if (ef) begin ep = 1'b0; s_e_stb = 1'b0; end
            t++;
        end
        check("send_done", 32'(xp || ep), 32'd0);
    endtask

    task automatic wait_pass();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !s_x_rdy) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check("pass_done", 32'(sb_q.size() == 0 && s_x_rdy), 32'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++) check(tag, 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic pass_basic(input string tag);
        preset(16'd255);
        expect_pass(16'd256, 16'd255, 16'd256, N);
        busy = 0;
        for (int i = 0; i < N; i++) send(1'b1, i, 16'd256, 1'b0, '0);
        send(1'b0, 0, '0, 1'b1, 16'd256);
        wait_pass();
        check({tag, "_cycles"}, 32'(busy), 32'(3 * N));
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int t;
        bit found;
        rst = 1'b0;
        s_x_stb = 1'b0; s_x_dat = '0; s_x_adr = '0;
        s_e_stb = 1'b0; s_e_dat = '0;
        ar_rdy = 1'b1; aw_rdy = 1'b1; w_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_stb", 32'({ar_stb, aw_stb, w_stb, m_e_stb}), 32'd0);
        check("rst_rdy", 32'({s_x_rdy, s_e_rdy, r_rdy}), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_before_edge_rdy", 32'({s_x_rdy, s_e_rdy}), 32'd0);
        @(posedge clk); #1;
        check("rel_rdy", 32'({s_x_rdy, s_e_rdy}), 32'b11);

        // Basic pass: weights 255, x 256, delta 256.
        pass_basic("basic");

        // Negative delta, x 0; x[0] first written with junk then overwritten; x0 and delta
        // offered in the same cycle.
        preset(16'd255);
        expect_pass(16'hFF00, 16'd255, 16'd0, N);
        busy = 0;
        send(1'b1, 0, 16'h1234, 1'b0, '0);
        send(1'b1, 0, 16'd0, 1'b1, 16'hFF00);
        for (int i = 1; i < N; i++) send(1'b1, i, 16'd0, 1'b0, '0);
        wait_pass();
        check("neg_cycles", 32'(busy), 32'(3 * N));
        check_mem("neg_mem");

        // Delta first, x out of order; nothing starts before the last x.
        preset(16'd255);
        expect_pass(16'd256, 16'd255, 16'd256, N);
        send(1'b0, 0, '0, 1'b1, 16'd256);
        check("order_e_rdy_low", 32'(s_e_rdy), 32'd0);
        send(1'b1, 3, 16'd256, 1'b0, '0);
        send(1'b1, 1, 16'd256, 1'b0, '0);
        send(1'b1, 0, 16'd256, 1'b0, '0);
        repeat (2) @(negedge clk);
        check("order_no_early_ar", 32'(ar_stb), 32'd0);
        @(posedge clk); #1;
        send(1'b1, 2, 16'd256, 1'b0, '0);
        wait_pass();
        check_mem("order_mem");

        // Downstream stall on every element.
        preset(16'd100);
        stall_mode = 1'b1;
        expect_pass(16'd512, 16'd100, 16'd128, N);
        for (int i = 0; i < N; i++) send(1'b1, i, 16'd128, 1'b0, '0);
        send(1'b0, 0, '0, 1'b1, 16'd512);
        wait_pass();
        stall_mode = 1'b0;
        check_mem("stall_mem");

        // Reset while waiting for weight 2's read data.
        preset(16'd255);
        hold_adr = 2;
        expect_pass(16'd256, 16'd255, 16'd256, 2);
        for (int i = 0; i < N; i++) send(1'b1, i, 16'd256, 1'b0, '0);
        send(1'b0, 0, '0, 1'b1, 16'd256);
        found = 1'b0; t = 0;
        while (!found && t < 200) begin
            @(negedge clk);
            found = ar_stb && ar_rdy && (ar_dat == 2'd2);
            t++;
        end
        check("midrst_reach_data", 32'(found), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_stb", 32'({ar_stb, aw_stb, w_stb, m_e_stb}), 32'd0);
        check("midrst_rdy", 32'({s_x_rdy, s_e_rdy, r_rdy}), 32'd0);
        check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
        check_mem("midrst_mem");
        hold_adr = -1;
        rst = 1'b1;
        @(posedge clk); #1;
        pass_basic("after_rst");

`ifdef BACKWARD_UPDATE_EN
        check("write_strobe_seen", 32'(aw_seen > 0), 32'd1);
`else
        check("no_write_strobe", 32'(aw_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no summary, expected end of test");
        $fatal(1);
    end

endmodule
